// File: rtl/evt_crossbar_pkg.sv
// Shared types and helpers for the event crossbar.
// Both master- and slave-side devices import this package.
package evt_crossbar_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BCAST = 1'b1
  } state_e;

  // Index width for a port count. It never returns less than 1, so a single-port build still gets a legal vector.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/evt_sat_counter.sv
// Saturating event counter. It holds at all-ones instead of wrapping.
// A synchronous clear takes priority over an increment.
module evt_sat_counter
  import evt_crossbar_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/evt_crossbar_mst_dev.sv
// Master-side crossbar port. It holds one event and broadcasts it to every mapped slave.
// The event retires once every mapped slave has accepted it.
module evt_crossbar_mst_dev
  import evt_crossbar_pkg::*;
#(
  parameter type         T         = logic,
  parameter int unsigned SRC_PORTS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  T                     data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output T                     data_o,
  output logic                 valid_o,
  input  logic [SRC_PORTS-1:0] ready_i,
  input  logic [SRC_PORTS-1:0] sel_i,
  output logic                 valid_mask_clean_o,
  output logic [CNT_W-1:0]     evt_cnt_o,
  output logic [CNT_W-1:0]     drop_cnt_o
);

  state_e               state_q;
  T                     data_q;
  logic [SRC_PORTS-1:0] sel_q;
  logic [SRC_PORTS-1:0] acc_q;

  logic [SRC_PORTS-1:0] hit;
  logic                 in_bcast;
  logic                 all_acc;
  logic                 retire;
  logic                 load;
  logic                 mapped;

  assign in_bcast = (state_q == BCAST);
  assign hit      = sel_q & ready_i;
  // Unmapped slaves count as accepted, so an empty mask retires on the first broadcast cycle.
  assign all_acc  = &(acc_q | hit | ~sel_q);
  assign retire   = in_bcast & all_acc & ~clear_i;
  assign ready_o  = ~clear_i & (~in_bcast | all_acc);
  assign load     = ready_o & valid_i;
  assign mapped   = |sel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
    end else if (clear_i) begin
      state_q <= EMPTY;
      acc_q   <= '0;
    end else if (load) begin
      state_q <= BCAST;
      data_q  <= data_i;
      sel_q   <= sel_i;
      acc_q   <= '0;
    end else if (retire) begin
      state_q <= EMPTY;
    end else if (in_bcast) begin
      acc_q <= acc_q | hit;
    end
  end

  assign valid_o = in_bcast;
  assign data_o  = data_q;
  // An abort also releases the slaves, so no slave stays masked on a discarded event.
  assign valid_mask_clean_o = in_bcast & (all_acc | clear_i);

  evt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_evt_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (retire & mapped),
    .clr_i  (clear_i),
    .cnt_o  (evt_cnt_o)
  );

  evt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (retire & ~mapped),
    .clr_i  (clear_i),
    .cnt_o  (drop_cnt_o)
  );

endmodule

// File: tb/tb_evt_crossbar_mst_dev.sv
// Bench for the master-side crossbar port with 8-bit payloads and 4-bit counters.
// A payload queue tracks events from input handshake to retirement.
module tb_evt_crossbar_mst_dev;

  logic       clk;
  logic       rst_ni;
  logic       clear_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic [3:0] ready_i;
  logic [3:0] sel_i;
  logic       valid_mask_clean_o;
  logic [3:0] evt_cnt_o;
  logic [3:0] drop_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  evt_crossbar_mst_dev #(
    .T         (logic [7:0]),
    .SRC_PORTS (4),
    .CNT_W     (4)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .clear_i            (clear_i),
    .data_i             (data_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .data_o             (data_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .sel_i              (sel_i),
    .valid_mask_clean_o (valid_mask_clean_o),
    .evt_cnt_o          (evt_cnt_o),
    .drop_cnt_o         (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at the negative edge. It retires or discards the head entry, records any new handshake, then moves to just after the next rising edge.
  task automatic sb_step();
    logic [7:0] e;
    if (valid_o && valid_mask_clean_o) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: clean pulse with data %0h but nothing expected", data_o);
      end else begin
        e = exp_q.pop_front();
        if (!clear_i) begin
          total++;
          if (data_o !== e) begin
            bad++;
            $display("FAIL sb_data: got %0h expected %0h", data_o, e);
          end
        end
      end
    end
    if (valid_i && ready_o) exp_q.push_back(data_i);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; data_i = '0; valid_i = 1'b0;
    ready_i = '0; sel_i = '0;
    #12;
    total++;
    if ({valid_o, valid_mask_clean_o, data_o, evt_cnt_o, drop_cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got v=%b c=%b d=%0h e=%0d dr=%0d expected all 0",
               valid_o, valid_mask_clean_o, data_o, evt_cnt_o, drop_cnt_o);
    end
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_back_to_back();
    sel_i = 4'b0101; ready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      valid_i = (i < 3);
      data_i  = (i < 3) ? 8'h0A + 8'(i) : 8'h00;
      @(negedge clk);
      total++;
      if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready c%0d: got %b expected 1", i, ready_o); end
      if (i > 0) begin
        total++;
        if ({valid_o, valid_mask_clean_o} !== 2'b11) begin
          bad++; $display("FAIL b2b_vld_clean c%0d: got %b%b expected 11", i, valid_o, valid_mask_clean_o);
        end
      end
      sb_step();
    end
    @(negedge clk);
    total++;
    if (evt_cnt_o !== 4'd3 || valid_o !== 1'b0) begin
      bad++; $display("FAIL b2b_cnt: got evt=%0d v=%b expected 3 0", evt_cnt_o, valid_o);
    end
    sb_step();
  endtask

  task automatic test_partial_accept();
    logic [3:0] rdy_seq [5];
    rdy_seq = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1111};
    sel_i = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      ready_i = rdy_seq[i];
      valid_i = (i < 4);
      data_i  = (i == 0) ? 8'h22 : 8'h33;
      @(negedge clk);
      if (i == 1 || i == 2) begin
        total++;
        if ({valid_o, valid_mask_clean_o, ready_o} !== 3'b100 || data_o !== 8'h22) begin
          bad++; $display("FAIL part_hold c%0d: got v=%b c=%b r=%b d=%0h expected 1 0 0 22",
                          i, valid_o, valid_mask_clean_o, ready_o, data_o);
        end
      end
      if (i == 3) begin
        total++;
        if ({valid_mask_clean_o, ready_o} !== 2'b11) begin
          bad++; $display("FAIL part_retire: got c=%b r=%b expected 1 1", valid_mask_clean_o, ready_o);
        end
      end
      sb_step();
    end
    @(negedge clk);
    total++;
    if (evt_cnt_o !== 4'd5) begin bad++; $display("FAIL part_cnt: got %0d expected 5", evt_cnt_o); end
    sb_step();
  endtask

  task automatic test_unmapped();
    sel_i = 4'b0000; ready_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      valid_i = (i == 0);
      data_i  = 8'h05;
      @(negedge clk);
      if (i == 1) begin
        total++;
        if ({valid_o, valid_mask_clean_o} !== 2'b11) begin
          bad++; $display("FAIL unmap_clean: got %b%b expected 11", valid_o, valid_mask_clean_o);
        end
      end
      if (i == 2) begin
        total++;
        if (drop_cnt_o !== 4'd1 || evt_cnt_o !== 4'd5 || valid_o !== 1'b0) begin
          bad++; $display("FAIL unmap_cnt: got drop=%0d evt=%0d v=%b expected 1 5 0",
                          drop_cnt_o, evt_cnt_o, valid_o);
        end
      end
      sb_step();
    end
  endtask

  task automatic test_remap();
    for (int i = 0; i < 5; i++) begin
      valid_i = (i == 0);
      data_i  = 8'h44;
      sel_i   = (i == 0) ? 4'b1000 : 4'b0001;
      ready_i = (i == 3) ? 4'b1000 : ((i == 0) ? 4'b0000 : 4'b0001);
      @(negedge clk);
      if (i == 1 || i == 2) begin
        total++;
        if ({valid_o, valid_mask_clean_o} !== 2'b10) begin
          bad++; $display("FAIL remap_hold c%0d: got %b%b expected 10", i, valid_o, valid_mask_clean_o);
        end
      end
      if (i == 3) begin
        total++;
        if (valid_mask_clean_o !== 1'b1) begin bad++; $display("FAIL remap_retire: got %b expected 1", valid_mask_clean_o); end
      end
      if (i == 4) begin
        total++;
        if (evt_cnt_o !== 4'd6) begin bad++; $display("FAIL remap_cnt: got %0d expected 6", evt_cnt_o); end
      end
      sb_step();
    end
  endtask

  task automatic test_clear();
    sel_i = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      valid_i = (i == 0 || i == 2);
      data_i  = (i == 0) ? 8'h55 : 8'h66;
      ready_i = (i == 1) ? 4'b0010 : 4'b0000;
      clear_i = (i == 2);
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (valid_mask_clean_o !== 1'b0) begin bad++; $display("FAIL clr_partial: got %b expected 0", valid_mask_clean_o); end
      end
      if (i == 2) begin
        total++;
        if ({valid_mask_clean_o, ready_o} !== 2'b10) begin
          bad++; $display("FAIL clr_cycle: got c=%b r=%b expected 1 0", valid_mask_clean_o, ready_o);
        end
      end
      if (i == 3) begin
        total++;
        if ({valid_o, valid_mask_clean_o, evt_cnt_o, drop_cnt_o} !== '0) begin
          bad++; $display("FAIL clr_after: got v=%b c=%b evt=%0d drop=%0d expected all 0",
                          valid_o, valid_mask_clean_o, evt_cnt_o, drop_cnt_o);
        end
      end
      sb_step();
    end
    clear_i = 1'b0;
  endtask

  task automatic test_saturate_and_async_reset();
    sel_i = 4'b0001; ready_i = 4'b1111;
    for (int i = 0; i < 18; i++) begin
      valid_i = (i < 16);
      data_i  = 8'h80 + 8'(i);
      @(negedge clk);
      if (i == 16 || i == 17) begin
        total++;
        if (evt_cnt_o !== 4'd15) begin bad++; $display("FAIL sat_cnt c%0d: got %0d expected 15", i, evt_cnt_o); end
      end
      sb_step();
    end
    ready_i = 4'b0000; valid_i = 1'b1; data_i = 8'hE7;
    @(negedge clk);
    sb_step();
    valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b1 || data_o !== 8'hE7) begin
      bad++; $display("FAIL arst_pre: got v=%b d=%0h expected 1 e7", valid_o, data_o);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if ({valid_o, valid_mask_clean_o, data_o, evt_cnt_o, drop_cnt_o} !== '0) begin
      bad++; $display("FAIL arst_outs: got v=%b c=%b d=%0h evt=%0d drop=%0d expected all 0",
                      valid_o, valid_mask_clean_o, data_o, evt_cnt_o, drop_cnt_o);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial_accept();
    test_unmapped();
    test_remap();
    test_clear();
    test_saturate_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
